// File: rtl/sample_fifo_if.sv
// sample_fifo_if: write/read request bus and status for sample_fifo.
// Optional feature macro: SAMPLE_FIFO_ERR_FLAGS_EN adds overflow/underflow status.
// master = producer/consumer side, slave = the FIFO itself.
interface sample_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
);
  logic                  wrreq;
  logic [DATA_WIDTH-1:0] data;
  logic                  rdreq;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH:0]   rdusedw;
  logic                  full;
  logic                  empty;
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (output wrreq, data, rdreq,
                  input  q, rdusedw, full, empty, overflow, underflow);
  modport slave  (input  wrreq, data, rdreq,
                  output q, rdusedw, full, empty, overflow, underflow);
`else
  modport master (output wrreq, data, rdreq,
                  input  q, rdusedw, full, empty);
  modport slave  (input  wrreq, data, rdreq,
                  output q, rdusedw, full, empty);
`endif
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock FIFO buffering audio samples ahead of the FFT sequencer.
// Latency: q registered, valid 1 cycle after an accepted rdreq; rdusedw updates next cycle.
// Backpressure: writes dropped while full, reads ignored while empty (no fall-through).
// Optional feature macro: SAMPLE_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic         clk,
  input  logic         reset,
  sample_fifo_if.slave fifo
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // Count needs one extra bit so a completely full buffer reads as DEPTH, not 0.
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   used_q, used_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  full, empty, wr_ok, rd_ok;

  assign full  = (used_q == CNT_FULL);
  assign empty = (used_q == '0);
  // Full/empty gate the requests, so a write into an empty FIFO is never
  // readable on the same edge and a read from a full FIFO always frees a slot.
  assign wr_ok = fifo.wrreq & ~full;
  assign rd_ok = fifo.rdreq & ~empty;

  // Next-state for pointers (natural power-of-two wrap) and stored-word count.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    used_d = used_q;
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (rd_ok) rptr_d = rptr_q + PTR_ONE;
    if (wr_ok && !rd_ok)      used_d = used_q + CNT_ONE;
    else if (rd_ok && !wr_ok) used_d = used_q - CNT_ONE;
  end

  // Pointer and count registers; reset empties the FIFO and wins over requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      used_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      used_q <= used_d;
    end
  end

  // Storage array: no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wptr_q] <= fifo.data;
  end

  // Registered read port; holds the last word popped when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset)      rd_data_q <= '0;
    else if (rd_ok) rd_data_q <= mem[rptr_q];
  end

  assign fifo.q       = rd_data_q;
  assign fifo.rdusedw = used_q;
  assign fifo.full    = full;
  assign fifo.empty   = empty;

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags: record any rejected request until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fifo.wrreq && full)  overflow_q  <= 1'b1;
      if (fifo.rdreq && empty) underflow_q <= 1'b1;
    end
  end

  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// tb_sample_fifo: self-checking bench for sample_fifo (small ADDR_WIDTH=3 and default instance).
// Scoreboard queue holds accepted writes; reads pop the expected word.
// Flag checks compile in when SAMPLE_FIFO_ERR_FLAGS_EN is defined.
module tb_sample_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, rst_b;

  sample_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3))  sif();
  sample_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) bif();

  sample_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
    .clk   (clk),
    .reset (rst_s),
    .fifo  (sif.slave)
  );

  sample_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .fifo  (bif.slave)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb[$];
  int          m_cnt;
  logic [15:0] m_q;
  bit          m_ovf, m_udf;
  logic [21:0] obs_v, exp_v;

  // Drive one cycle on the small FIFO and advance the reference model.
  task automatic step(input bit wr, input logic [15:0] d, input bit rd);
    bit w_ok, r_ok;
    w_ok = wr && (m_cnt < 8);
    r_ok = rd && (m_cnt > 0);
    if (wr && m_cnt == 8) m_ovf = 1'b1;
    if (rd && m_cnt == 0) m_udf = 1'b1;
    sif.wrreq = wr; sif.data = d; sif.rdreq = rd;
    @(posedge clk); #1;
    sif.wrreq = 1'b0; sif.rdreq = 1'b0;
    if (r_ok) begin m_q = sb.pop_front(); m_cnt--; end
    if (w_ok) begin sb.push_back(d); m_cnt++; end
  endtask

  task automatic apply_reset_s;
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    sb.delete(); m_cnt = 0; m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_reset;
    rst_s = 1'b1; sif.wrreq = 1'b1; sif.data = 16'h1234; sif.rdreq = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0; sif.wrreq = 1'b0; sif.rdreq = 1'b0;
    sb.delete(); m_cnt = 0; m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (sif.rdusedw !== 4'd0 || sif.empty !== 1'b1 || sif.full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: rdusedw=%0d empty=%b full=%b, want 0/1/0", sif.rdusedw, sif.empty, sif.full);
    end
    n_checks++;
    if (sif.q !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_q: q=%h, want 0000", sif.q);
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (sif.overflow !== 1'b0 || sif.underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err_flags: ovf=%b udf=%b, want 0/0", sif.overflow, sif.underflow);
    end
`endif
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 1'b0);
      obs_v = {sif.q, sif.rdusedw, sif.full, sif.empty};
      exp_v = {m_q, 4'(m_cnt), m_cnt == 8, m_cnt == 0};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_errors++;
        $display("FAIL fill_%0d: {q,used,full,empty}=%h, want %h", i, obs_v, exp_v);
      end
    end
    step(1'b1, 16'hFFFF, 1'b0);
    n_checks++;
    if (sif.rdusedw !== 4'd8 || sif.full !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_overflow_drop: rdusedw=%0d full=%b, want 8/1", sif.rdusedw, sif.full);
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (sif.overflow !== 1'b1 || sif.underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL overflow_flag: ovf=%b udf=%b, want 1/0", sif.overflow, sif.underflow);
    end
`endif
  endtask

  task automatic test_drain;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if (sif.q !== 16'(i) || sif.rdusedw !== 4'(m_cnt)) begin
        n_errors++;
        $display("FAIL drain_%0d: q=%h used=%0d, want %h/%0d", i, sif.q, sif.rdusedw, 16'(i), m_cnt);
      end
    end
    n_checks++;
    if (sif.empty !== 1'b1 || sif.rdusedw !== 4'd0) begin
      n_errors++;
      $display("FAIL drain_empty: empty=%b used=%0d, want 1/0", sif.empty, sif.rdusedw);
    end
    step(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (sif.q !== 16'h0008 || sif.rdusedw !== 4'd0) begin
      n_errors++;
      $display("FAIL underflow_hold: q=%h used=%0d, want 0008/0", sif.q, sif.rdusedw);
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (sif.underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow_flag: udf=%b, want 1", sif.underflow);
    end
`endif
  endtask

  task automatic test_concurrent;
    apply_reset_s();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h0100 + 16'(i), 1'b1);
      n_checks++;
      if (sif.rdusedw !== 4'd4 || sif.q !== m_q) begin
        n_errors++;
        $display("FAIL concurrent_%0d: used=%0d q=%h, want 4/%h", i, sif.rdusedw, sif.q, m_q);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if (sif.q !== m_q || sif.rdusedw !== 4'(m_cnt)) begin
        n_errors++;
        $display("FAIL concurrent_tail_%0d: q=%h used=%0d, want %h/%0d", i, sif.q, sif.rdusedw, m_q, m_cnt);
      end
    end
    n_checks++;
    if (sif.q !== 16'h0109 || sif.empty !== 1'b1) begin
      n_errors++;
      $display("FAIL concurrent_last: q=%h empty=%b, want 0109/1", sif.q, sif.empty);
    end
  endtask

  task automatic test_simul_edges;
    // Empty: write wins, read ignored, q must not fall through.
    step(1'b1, 16'h0ABC, 1'b1);
    n_checks++;
    if (sif.rdusedw !== 4'd1 || sif.q !== 16'h0109) begin
      n_errors++;
      $display("FAIL simul_empty: used=%0d q=%h, want 1/0109", sif.rdusedw, sif.q);
    end
    for (int i = 1; i <= 7; i++) step(1'b1, 16'h0B00 + 16'(i), 1'b0);
    // Full: read wins, write dropped.
    step(1'b1, 16'hDEAD, 1'b1);
    n_checks++;
    if (sif.rdusedw !== 4'd7 || sif.q !== 16'h0ABC || sif.full !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_full: used=%0d q=%h full=%b, want 7/0abc/0", sif.rdusedw, sif.q, sif.full);
    end
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if (sif.q !== m_q || sif.q !== 16'h0B00 + 16'(i)) begin
        n_errors++;
        $display("FAIL simul_drain_%0d: q=%h, want %h", i, sif.q, 16'h0B00 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset_s();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0);
    n_checks++;
    if (sif.rdusedw !== 4'd5) begin
      n_errors++;
      $display("FAIL reset_mid_pre: used=%0d, want 5", sif.rdusedw);
    end
    rst_s = 1'b1; sif.wrreq = 1'b1; sif.data = 16'hBEEF;
    @(posedge clk); #1;
    rst_s = 1'b0; sif.wrreq = 1'b0;
    sb.delete(); m_cnt = 0; m_q = '0; m_ovf = 1'b0; m_udf = 1'b0;
    n_checks++;
    if (sif.rdusedw !== 4'd0 || sif.empty !== 1'b1 || sif.q !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_mid: used=%0d empty=%b q=%h, want 0/1/0000", sif.rdusedw, sif.empty, sif.q);
    end
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    n_checks++;
    if (sif.overflow !== 1'b0 || sif.underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_flags: ovf=%b udf=%b, want 0/0", sif.overflow, sif.underflow);
    end
`endif
    step(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if (sif.rdusedw !== 4'd0 || sif.q !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_mid_discard: used=%0d q=%h, want 0/0000", sif.rdusedw, sif.q);
    end
  endtask

  task automatic test_big;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      bif.wrreq = 1'b1;
      bif.data  = 16'(i) ^ 16'hA5A5;
      @(posedge clk); #1;
    end
    bif.data = 16'h5555;
    @(posedge clk); #1;
    bif.wrreq = 1'b0;
    n_checks++;
    if (bif.rdusedw !== 16'h8000 || bif.full !== 1'b1 || bif.empty !== 1'b0) begin
      n_errors++;
      $display("FAIL big_full: used=%h full=%b empty=%b, want 8000/1/0", bif.rdusedw, bif.full, bif.empty);
    end
    bif.rdreq = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bif.q !== 16'hA5A5 || bif.rdusedw !== 16'h7FFF || bif.full !== 1'b0) begin
      n_errors++;
      $display("FAIL big_first: q=%h used=%h full=%b, want a5a5/7fff/0", bif.q, bif.rdusedw, bif.full);
    end
    @(posedge clk); #1;
    bif.rdreq = 1'b0;
    n_checks++;
    if (bif.q !== 16'hA5A4 || bif.rdusedw !== 16'h7FFE) begin
      n_errors++;
      $display("FAIL big_second: q=%h used=%h, want a5a4/7ffe", bif.q, bif.rdusedw);
    end
  endtask

  initial begin
    rst_s = 1'b1; rst_b = 1'b1;
    sif.wrreq = 1'b0; sif.rdreq = 1'b0; sif.data = '0;
    bif.wrreq = 1'b0; bif.rdreq = 1'b0; bif.data = '0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_simul_edges();
    test_reset_mid();
    test_big();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
